// File: rtl/axi_framefill_pkg.sv
// Shared AXI encodings, FSM state and fill-mode types for the framebuffer fill engine.
package axi_framefill_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [3:0] CACHE_DEF   = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        MODE_SOLID     = 2'd0,
        MODE_RAMP      = 2'd1,
        MODE_CHECKER   = 2'd2,
        MODE_SOLID_ALT = 2'd3
    } mode_e;

endpackage

// File: rtl/axi_framefill_pattern.sv
// Registered write-data generator: loaded with the first beat's position at burst
// start, then stepped one word along the line on every accepted W beat.
module axi_framefill_pattern
    import axi_framefill_pkg::*;
#(
    parameter int AW    = 26,
    parameter int DW    = 32,
    parameter int LGDIM = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [1:0]       mode_i,
    input  logic [DW-1:0]    color_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [LGDIM-1:0] col_i,
    input  logic [LGDIM-1:0] row_i,
    output logic [DW-1:0]    data_o
);

    localparam int STEP = DW / 8;

    logic [AW-1:0]    addr_q;
    logic [LGDIM-1:0] col_q;
    logic [LGDIM-1:0] row_q;
    logic [DW-1:0]    data_q;

    function automatic logic [DW-1:0] gen_word(input logic [AW-1:0] a,
                                               input logic [LGDIM-1:0] c,
                                               input logic [LGDIM-1:0] r);
        logic [DW-1:0] w;
        case (mode_e'(mode_i))
            MODE_RAMP:    w = DW'(a);
            // 16x16-word checker cells
            MODE_CHECKER: w = (c[4] ^ r[4]) ? ~color_i : color_i;
            default:      w = color_i;
        endcase
        return w;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
            data_q <= '0;
        end else if (load_i) begin
            addr_q <= addr_i;
            col_q  <= col_i;
            row_q  <= row_i;
            data_q <= gen_word(addr_i, col_i, row_i);
        end else if (adv_i) begin
            addr_q <= addr_q + AW'(STEP);
            col_q  <= col_q + 1'b1;
            data_q <= gen_word(addr_q + AW'(STEP), col_q + 1'b1, row_q);
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/axi_framefill.sv
// AXI4 write-only burst master filling a rectangular framebuffer region with a
// generated pattern; one burst in flight, bursts never cross a line or 4KB page.
module axi_framefill
    import axi_framefill_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = 26,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int LGMAXBURST       = 8,
    parameter int LGDIM            = 12
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESETN,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic [C_AXI_ADDR_WIDTH-1:0] i_base,
    input  logic [C_AXI_ADDR_WIDTH-1:0] i_stride,
    input  logic [LGDIM-1:0]            i_line_words,
    input  logic [LGDIM-1:0]            i_lines,
    input  logic [1:0]                  i_mode,
    input  logic [C_AXI_DATA_WIDTH-1:0] i_color,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err,
    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic [C_AXI_ID_WIDTH-1:0]   M_AXI_AWID,
    output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [7:0]                  M_AXI_AWLEN,
    output logic [2:0]                  M_AXI_AWSIZE,
    output logic [1:0]                  M_AXI_AWBURST,
    output logic                        M_AXI_AWLOCK,
    output logic [3:0]                  M_AXI_AWCACHE,
    output logic [2:0]                  M_AXI_AWPROT,
    output logic [3:0]                  M_AXI_AWQOS,
    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    output logic [C_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                        M_AXI_WLAST,
    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]   M_AXI_BID,
    input  logic [1:0]                  M_AXI_BRESP
);

    localparam int AW  = C_AXI_ADDR_WIDTH;
    localparam int DW  = C_AXI_DATA_WIDTH;
    localparam int LSB = $clog2(DW / 8);
    localparam int CW  = ((LGDIM > 12) ? LGDIM : 12) + 1;

    state_e           state_q;
    logic [AW-1:0]    line_addr_q, word_addr_q, stride_q, awaddr_q;
    logic [LGDIM-1:0] words_q, lines_q, col_q, row_q;
    logic [1:0]       mode_q;
    logic [DW-1:0]    color_q;
    logic [CW-1:0]    len_q;
    logic [7:0]       awlen_q, beat_q;
    logic             awvalid_q, wvalid_q, wlast_q, bready_q;
    logic             abort_q, err_q, done_q;

    logic [CW-1:0]    words_left, to_4k, max_burst, burst_len;
    logic [AW-1:0]    next_line;
    logic             line_end, region_done, bus_err, aw_hs, w_hs;
    logic             unused_bid;

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return {a[AW-1:LSB], {LSB{1'b0}}};
    endfunction

    // Next burst: the tightest of line remainder, max burst and words left in the 4KB page
    always_comb begin
        words_left = CW'(words_q - col_q);
        to_4k      = CW'((13'h1000 - {1'b0, word_addr_q[11:0]}) >> LSB);
        max_burst  = CW'(1) << LGMAXBURST;
        burst_len  = words_left;
        if (to_4k < burst_len) burst_len = to_4k;
        if (max_burst < burst_len) burst_len = max_burst;
    end

    assign next_line   = line_addr_q + stride_q;
    assign line_end    = (col_q == words_q);
    assign region_done = line_end && (row_q == lines_q - 1'b1);
    assign bus_err     = (M_AXI_BRESP == RESP_SLVERR) || (M_AXI_BRESP == RESP_DECERR);
    assign aw_hs       = (state_q == ST_ADDR) && awvalid_q && M_AXI_AWREADY;
    assign w_hs        = (state_q == ST_DATA) && wvalid_q && M_AXI_WREADY;
    assign unused_bid  = ^M_AXI_BID;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            line_addr_q <= '0;
            word_addr_q <= '0;
            stride_q    <= '0;
            awaddr_q    <= '0;
            words_q     <= '0;
            lines_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= '0;
            color_q     <= '0;
            len_q       <= '0;
            awlen_q     <= '0;
            beat_q      <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != ST_IDLE && i_abort)
                abort_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        line_addr_q <= align(i_base);
                        word_addr_q <= align(i_base);
                        stride_q    <= i_stride;
                        words_q     <= i_line_words;
                        lines_q     <= i_lines;
                        mode_q      <= i_mode;
                        color_q     <= i_color;
                        col_q       <= '0;
                        row_q       <= '0;
                        err_q       <= 1'b0;
                        abort_q     <= 1'b0;
                        if (i_line_words == '0 || i_lines == '0)
                            done_q  <= 1'b1;
                        else
                            state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (!awvalid_q) begin
                        awvalid_q <= 1'b1;
                        awaddr_q  <= word_addr_q;
                        awlen_q   <= 8'(burst_len - 1'b1);
                        len_q     <= burst_len;
                    end else if (M_AXI_AWREADY) begin
                        awvalid_q   <= 1'b0;
                        wvalid_q    <= 1'b1;
                        wlast_q     <= (awlen_q == 8'd0);
                        beat_q      <= '0;
                        word_addr_q <= word_addr_q + (AW'(len_q) << LSB);
                        col_q       <= col_q + LGDIM'(len_q);
                        state_q     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (wvalid_q && M_AXI_WREADY) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= ST_RESP;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            wlast_q <= (beat_q + 8'd1 == awlen_q);
                        end
                    end
                end
                ST_RESP: begin
                    if (M_AXI_BVALID) begin
                        bready_q <= 1'b0;
                        if (bus_err) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (abort_q || i_abort || region_done) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_ADDR;
                            if (line_end) begin
                                row_q       <= row_q + 1'b1;
                                col_q       <= '0;
                                line_addr_q <= next_line;
                                word_addr_q <= align(next_line);
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    axi_framefill_pattern #(
        .AW    (AW),
        .DW    (DW),
        .LGDIM (LGDIM)
    ) u_pattern (
        .clk_i   (S_AXI_ACLK),
        .rst_ni  (S_AXI_ARESETN),
        .load_i  (aw_hs),
        .adv_i   (w_hs),
        .mode_i  (mode_q),
        .color_i (color_q),
        .addr_i  (word_addr_q),
        .col_i   (col_q),
        .row_i   (row_q),
        .data_o  (M_AXI_WDATA)
    );

    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = done_q;
    assign o_err         = err_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = awlen_q;
    assign M_AXI_AWSIZE  = 3'(LSB);
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = CACHE_DEF;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = wlast_q;
    assign M_AXI_BREADY  = bready_q;

endmodule
